pipe_adder: RTL
===============

// Module: pipe_adder
// PURPOSE
//  Parametrised pipelined ripple-carry adder; next generation of the registered 1-bit half adder.
//  Adds two WIDTH-bit operands plus carry-in. Carry chain is split into STAGES registered slices.
//  Valid/ready handshake on both sides with full backpressure. Sits between operand and result registers in the datapath.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be >= 1
//  STAGES  2   carry-chain slices, each followed by a register; WIDTH % STAGES == 0, 1 <= STAGES <= WIDTH
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      a_in/b_in/c_in valid this cycle
//  in_ready   out  1      block accepts the input this cycle
//  a_in       in   WIDTH  operand A, unsigned (signed view only for ovf_out)
//  b_in       in   WIDTH  operand B
//  c_in       in   1      carry-in
//  out_valid  out  1      sum_out/carry_out valid
//  out_ready  in   1      downstream accepts the result this cycle
//  sum_out    out  WIDTH  (a+b+c_in) mod 2^WIDTH
//  carry_out  out  1      bit WIDTH of a+b+c_in
//  ovf_out    out  1      signed overflow; present only with PIPE_ADDER_OVF_EN
// BEHAVIOUR
//  - Reset (rst=1, async): every valid bit, sum_out, carry_out and ovf_out go to 0 at once. All data regs clear.
//  - Release of reset is synchronous to clk.
//  - CHUNK = WIDTH/STAGES. Pipeline = input reg (stage 0) + STAGES slice regs (stages 1..STAGES).
//  - Slice k adds bits [k*CHUNK +: CHUNK] plus the carry registered by slice k-1 (c_in for k=0).
//  - Upper operand bits ride along delayed; finished lower sum bits ride along.
//  - advance = !out_valid || out_ready. in_ready = advance. This is a combinational path from out_ready.
//  - Every stage register (data and valid) loads from its predecessor only when advance=1; else all hold.
//  - Input accepted when in_valid && in_ready. Stage-0 valid <= in_valid on advance, so bubbles propagate.
//  - Bubbles are not compressed.
//  - Latency: result appears on out_valid exactly STAGES+1 cycles after acceptance when out_ready is held 1.
//  - Throughput: one result per cycle when out_ready=1.
//  - Output held stable (sum/carry/ovf unchanged) while out_valid && !out_ready. No data loss or duplication.
//  - Data regs of invalid stages may update. Outputs are only meaningful when out_valid=1.
//  - Wrap-around: 0xFFFF+0x0000+1 -> sum 0x0000, carry 1. No saturation.
//  - Rst asserted mid-operation: all in-flight results are discarded. First out_valid after release needs a new accept.
//  - in_valid with in_ready=0: the input is not captured. The source must hold it.
// CONFIGURATION
//  PIPE_ADDER_OVF_EN defined: port ovf_out exists.
//    ovf_out = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), computed in the last slice.
//    ovf_out is registered and aligned with sum_out.
//  PIPE_ADDER_OVF_EN undefined: no ovf_out port, no sign logic. All other behaviour is identical.
// STRUCTURE
//  Package pipe_adder_pkg:
//    function chunk_w(WIDTH,STAGES)
//    typedef of the per-stage record {valid, a_rem, b_rem, sum_done, carry}
//  Sub-module pipe_adder_slice:
//    one CHUNK-bit add plus register, enable=advance, async rst
//    instantiated STAGES times in a generate loop
//  Top holds the input reg, the advance/in_ready logic and the output mapping.
// TESTING (WIDTH=16, STAGES=2 unless noted)
//  1. 0x1234+0x4321, c_in=0, out_ready=1 -> after 3 cycles out_valid=1, sum 0x5555, carry 0.
//  2. 0xFFFF+0x0001, c_in=0 -> sum 0x0000, carry 1. Checks the carry across the slice boundary.
//     Also 0x00FF+0x0001 -> 0x0100.
//  3. 8 back-to-back accepts, out_ready=1 -> 8 consecutive out_valid cycles, in order, matching a reference model.
//  4. Stream with out_ready=0 for 5 cycles mid-burst:
//     -> in_ready=0, outputs frozen for those cycles.
//     -> on resume all results arrive once, in order.
//  5. Assert rst with 2 results in flight -> outputs 0 immediately. Nothing valid after release until a new input.
//  6. PIPE_ADDER_OVF_EN, 0x7FFF+0x0001 -> ovf 1. 0x8000+0x8000 -> ovf 1, carry 1. 0x0001+0x0001 -> ovf 0.
//     Also run WIDTH=8, STAGES=8 and STAGES=1 with a random compare against a+b+c.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder.
// Operand records are sized to MaxWidth; WIDTH must not exceed it.
package pipe_adder_pkg;

  localparam int unsigned MaxWidth = 64;

  // One pipeline stage: operand bits still to add, sum bits already finished, carry into next slice.
  typedef struct packed {
    logic                valid;
    logic [MaxWidth-1:0] a_rem;
    logic [MaxWidth-1:0] b_rem;
    logic [MaxWidth-1:0] sum_done;
    logic                carry;
  } stage_t;

  function automatic int unsigned chunk_w(int unsigned width, int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// One CHUNK-bit slice of the carry chain followed by its stage register.
// With PIPE_ADDER_OVF_EN defined, the last slice also registers the signed-overflow flag.
module pipe_adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int unsigned CHUNK = 8,
  parameter int unsigned IDX   = 0
`ifdef PIPE_ADDER_OVF_EN
  ,
  parameter bit          LAST  = 1'b1
`endif
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   advance,
  input  stage_t prev_stage,
  output stage_t this_stage
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic   ovf
`endif
);

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK:0]   total;
  stage_t           stage_d;
  stage_t           stage_q;

  always_comb begin
    a_chunk = prev_stage.a_rem[CHUNK-1:0];
    b_chunk = prev_stage.b_rem[CHUNK-1:0];
    total   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, prev_stage.carry};
    s_chunk = total[CHUNK-1:0];

    stage_d       = prev_stage;
    // Consumed operand bits shift out so the next slice always reads from bit 0.
    stage_d.a_rem = prev_stage.a_rem >> CHUNK;
    stage_d.b_rem = prev_stage.b_rem >> CHUNK;
    stage_d.sum_done[IDX*CHUNK +: CHUNK] = s_chunk;
    stage_d.carry = total[CHUNK];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (advance) begin
      stage_q <= stage_d;
    end
  end

  assign this_stage = stage_q;

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = LAST && (a_chunk[CHUNK-1] == b_chunk[CHUNK-1])
                      && (s_chunk[CHUNK-1] != a_chunk[CHUNK-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder with valid/ready handshake; carry chain split into STAGES slices.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf_out.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int unsigned Chunk = chunk_w(WIDTH, STAGES);

  stage_t stage0_d;
  stage_t stage0_q;
  stage_t slice_q [STAGES];
  stage_t last;
  logic   advance;
  logic   unused_last;

  assign last     = slice_q[STAGES-1];
  // Whole pipeline moves in lockstep; a stalled output freezes every stage.
  assign advance  = !last.valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    stage0_d       = '0;
    stage0_d.valid = in_valid;
    stage0_d.a_rem = MaxWidth'(a_in);
    stage0_d.b_rem = MaxWidth'(b_in);
    stage0_d.carry = c_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage0_q <= '0;
    end else if (advance) begin
      stage0_q <= stage0_d;
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  // Only the last slice can raise its flag; the others are tied low.
  logic [STAGES-1:0] slice_ovf;
  assign ovf_out = |slice_ovf;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    stage_t prev;
    if (k == 0) begin : g_first
      assign prev = stage0_q;
    end else begin : g_rest
      assign prev = slice_q[k-1];
    end

    pipe_adder_slice #(
      .CHUNK (Chunk),
      .IDX   (k)
`ifdef PIPE_ADDER_OVF_EN
      ,
      .LAST  (k == STAGES - 1)
`endif
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .advance    (advance),
      .prev_stage (prev),
      .this_stage (slice_q[k])
`ifdef PIPE_ADDER_OVF_EN
      ,
      .ovf        (slice_ovf[k])
`endif
    );
  end

  assign out_valid   = last.valid;
  assign sum_out     = last.sum_done[WIDTH-1:0];
  assign carry_out   = last.carry;
  assign unused_last = ^{last.a_rem, last.b_rem, last.sum_done};

endmodule
